// File: rtl/trace_port_pkg.sv
// Shared types and helpers for the trace port serializer: FSM states,
// beat-count arithmetic and overflow marker construction.
package trace_port_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic [23:0] OVF_TAG_DEFAULT = 24'hFFFF_FE;

  // Widest word the marker helper supports; callers truncate to their width.
  localparam int unsigned MARKER_MAX_W = 64;
  localparam int unsigned TAG_MAX_W    = MARKER_MAX_W - 8;

  function automatic int unsigned beats(input int unsigned word_w, input int unsigned port_w);
    return word_w / port_w;
  endfunction

  function automatic logic [MARKER_MAX_W-1:0] build_marker(input logic [TAG_MAX_W-1:0] tag,
                                                          input logic [7:0]           cnt);
    return {tag, cnt};
  endfunction

endpackage

// File: rtl/trace_word_fifo.sv
// Synchronous word FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable. Read data is the combinational head entry.
module trace_word_fifo #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Push at full aliases the head slot; the head was already read this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/trace_port_serializer.sv
// Buffers trace packet words, drops and counts on overflow with an in-band
// marker, and serializes each word LSB-beat-first onto a valid/ready port.
module trace_port_serializer
  import trace_port_pkg::*;
#(
  parameter int unsigned       WORD_W  = 32,
  parameter int unsigned       PORT_W  = 8,
  parameter int unsigned       DEPTH   = 8,
  parameter logic [WORD_W-9:0] OVF_TAG = OVF_TAG_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WORD_W-1:0]        packet_word_i,
  input  logic                     packet_word_valid_i,
  output logic [PORT_W-1:0]        trace_data_o,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [$clog2(DEPTH):0]   fill_level_o,
  output logic                     overflow_o,
  input  logic                     clear_overflow_i
);

  localparam int unsigned BEATS = beats(WORD_W, PORT_W);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TAG_MAX_W-1:0] TAG_EXT   = TAG_MAX_W'(OVF_TAG);

  ser_state_t        state;
  ser_state_t        state_next;
  logic [WORD_W-1:0] shift;
  logic [BW-1:0]     beat;
  logic [7:0]        drop_cnt;

  logic              fifo_push;
  logic              pop;
  logic              shift_adv;
  logic [WORD_W-1:0] fifo_wdata;
  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;

  logic              room;
  logic              marker_write;
  logic              accept;
  logic              drop;
  logic [WORD_W-1:0] marker_word;

  trace_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fifo_push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A pending marker blocks new input until it is written, so drops keep counting.
  assign room         = !fifo_full || pop;
  assign marker_write = (drop_cnt != '0) && room;
  assign accept       = packet_word_valid_i && room && (drop_cnt == '0);
  assign drop         = packet_word_valid_i && !accept;
  assign marker_word  = WORD_W'(build_marker(TAG_EXT, drop_cnt));
  assign fifo_push    = marker_write || accept;
  assign fifo_wdata   = marker_write ? marker_word : packet_word_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt   <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (marker_write)                drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;

      if (drop)                  overflow_o <= 1'b1;
      else if (clear_overflow_i) overflow_o <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    shift_adv  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (trace_ready_i) begin
          if (beat == LAST_BEAT) begin
            if (!fifo_empty) pop        = 1'b1;
            else             state_next = IDLE;
          end else begin
            shift_adv = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      shift <= '0;
      beat  <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        shift <= fifo_rdata;
        beat  <= '0;
      end else if (shift_adv) begin
        shift <= shift >> PORT_W;
        beat  <= beat + 1'b1;
      end
    end
  end

  assign trace_valid_o = (state == SHIFT);
  assign trace_data_o  = shift[PORT_W-1:0];
  assign fill_level_o  = fifo_count;

endmodule

// File: tb/tb_trace_port_serializer.sv
// Directed bench for trace_port_serializer: latency, backpressure, overflow
// markers, push-through at full and asynchronous reset mid-word.
module tb_trace_port_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] packet_word = '0;
  logic        packet_word_valid = 1'b0;
  logic [7:0]  trace_data;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  got[$];
  logic [31:0] exp_w[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  trace_port_serializer #(
    .WORD_W  (32),
    .PORT_W  (8),
    .DEPTH   (8),
    .OVF_TAG (24'hFFFF_FE)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .packet_word_i       (packet_word),
    .packet_word_valid_i (packet_word_valid),
    .trace_data_o        (trace_data),
    .trace_valid_o       (trace_valid),
    .trace_ready_i       (trace_ready),
    .fill_level_o        (fill_level),
    .overflow_o          (overflow),
    .clear_overflow_i    (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, observe, then advance.
  task automatic cycle(input logic v, input logic [31:0] w, input logic rdy);
    packet_word_valid = v;
    packet_word       = w;
    trace_ready       = rdy;
    #1;
    if (prev_stall && trace_valid) chk("hold", 32'(trace_data), 32'(prev_data));
    if (trace_valid && trace_ready) got.push_back(trace_data);
    prev_stall = trace_valid && !trace_ready;
    prev_data  = trace_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    packet_word_valid = 1'b0;
    trace_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got.delete();
    prev_stall = 1'b0;
  endtask

  task automatic chk_stream(input string tag);
    logic [7:0] exp_b[$];
    foreach (exp_w[i]) for (int b = 0; b < 4; b++) exp_b.push_back(exp_w[i][8*b +: 8]);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(exp_b[i]));
    got.delete();
    exp_w.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    do_reset();
    chk("rst_data", 32'(trace_data), 32'h0);
    chk("rst_valid", 32'(trace_valid), 32'h0);
    chk("rst_fill", 32'(fill_level), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // single word, ready held high
    cycle(1'b1, 32'hA1B2_C3D4, 1'b1);
    chk("t1_fill_push", 32'(fill_level), 32'd1);
    chk("t1_valid_lat1", 32'(trace_valid), 32'h0);
    cycle(1'b0, '0, 1'b1);
    chk("t1_valid_lat2", 32'(trace_valid), 32'h1);
    chk("t1_first_beat", 32'(trace_data), 32'hD4);
    chk("t1_fill_pop", 32'(fill_level), 32'd0);
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("t1_valid_end", 32'(trace_valid), 32'h0);
    chk("t1_fill_end", 32'(fill_level), 32'd0);
    exp_w.push_back(32'hA1B2_C3D4);
    chk_stream("t1_beat");

    // backpressure with ready pattern 1,0,0,1
    cycle(1'b1, 32'h1122_3344, 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 24; i++) cycle(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
    chk("t2_valid_end", 32'(trace_valid), 32'h0);
    exp_w.push_back(32'h1122_3344);
    chk_stream("t2_beat");

    // overflow: one word held in the shifter, then 12 words with ready low
    cycle(1'b1, 32'hCAFE_BABE, 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
    chk("t3_fill_full", 32'(fill_level), 32'd8);
    chk("t3_ovf_set", 32'(overflow), 32'h1);
    // input collides with the marker write on the last beat of the held word
    for (int i = 0; i < 60; i++) begin
      cycle(i == 3, 32'hDEAD_DEAD, 1'b1);
      if (i == 3) chk("t3_fill_marker", 32'(fill_level), 32'd8);
    end
    chk("t3_valid_end", 32'(trace_valid), 32'h0);
    chk("t3_fill_end", 32'(fill_level), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'h1);
    exp_w.push_back(32'hCAFE_BABE);
    for (int i = 0; i < 8; i++) exp_w.push_back(32'h1000_0000 + 32'(i));
    exp_w.push_back(32'hFFFF_FE04);
    exp_w.push_back(32'hFFFF_FE01);
    chk_stream("t3_beat");
    clear_overflow = 1'b1;
    cycle(1'b0, '0, 1'b0);
    clear_overflow = 1'b0;
    chk("t3_ovf_clear", 32'(overflow), 32'h0);

    // push-through at full on the last beat
    cycle(1'b1, 32'hCAFE_BABE, 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
    chk("t4_fill_full", 32'(fill_level), 32'd8);
    chk("t4_ovf_none", 32'(overflow), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h5A5A_5A5A, 1'b1);
    chk("t4_fill_pt", 32'(fill_level), 32'd8);
    chk("t4_ovf_pt", 32'(overflow), 32'h0);
    repeat (40) cycle(1'b0, '0, 1'b1);
    chk("t4_fill_end", 32'(fill_level), 32'd0);
    exp_w.push_back(32'hCAFE_BABE);
    for (int i = 0; i < 8; i++) exp_w.push_back(32'h2000_0000 + 32'(i));
    exp_w.push_back(32'h5A5A_5A5A);
    chk_stream("t4_beat");

    // asynchronous reset while beat 2 is on the port
    cycle(1'b1, 32'h8765_4321, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b1);
    chk("t5_beat2", 32'(trace_data), 32'h65);
    rst = 1'b1;
    #1;
    chk("t5_valid_async", 32'(trace_valid), 32'h0);
    chk("t5_data_async", 32'(trace_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    prev_stall = 1'b0;
    chk("t5_fill_rst", 32'(fill_level), 32'd0);
    chk("t5_ovf_rst", 32'(overflow), 32'h0);
    cycle(1'b1, 32'h0F1E_2D3C, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("t5_beat0", 32'(trace_data), 32'h3C);
    repeat (4) cycle(1'b0, '0, 1'b1);
    exp_w.push_back(32'h0F1E_2D3C);
    chk_stream("t5_beat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trace_port_serializer.md
Name: trace_port_serializer

Overview:
- Downstream stage of the trace debugger.
- Buffers the WORD_W-bit packet words it emits and serializes each word onto a narrow off-chip trace port of PORT_W bits, using a valid/ready handshake.
- The packet source has no backpressure, so the block must absorb bursts.
- On overflow it drops words, counts them, and injects an in-band overflow marker word so the host decoder can resynchronize.

Parameters:
- WORD_W, 32, packet word width; must be a multiple of PORT_W.
- PORT_W, 8, trace port width per beat.
- DEPTH, 8, FIFO depth in words; power of two, at least 2.
- OVF_TAG, 24'hFFFF_FE, upper WORD_W-8 bits of the overflow marker word.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- packet_word_i  in  WORD_W  packet word from the trace debugger.
- packet_word_valid_i  in  1  qualifies packet_word_i; no ready is returned.
- trace_data_o  out  PORT_W  current serialized beat.
- trace_valid_o  out  1  beat valid.
- trace_ready_i  in  1  sink accepts the beat.
- fill_level_o  out  $clog2(DEPTH)+1  number of FIFO entries.
- overflow_o  out  1  sticky; set on any dropped word.
- clear_overflow_i  in  1  synchronous clear of overflow_o.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, sync release):
  - trace_data_o=0, trace_valid_o=0, fill_level_o=0, overflow_o=0.
  - FIFO empty, drop count 0, FSM in IDLE.
  - Assertion mid-beat drops the in-flight word; trace_valid_o falls combinationally with rst_i.
- FIFO push:
  - pop = the serializer loading a word this cycle.
  - A word is accepted when packet_word_valid_i && (count<DEPTH || pop) && no marker pending; push-through at full is allowed when a pop happens in the same cycle.
  - Otherwise a valid word is dropped: drop_cnt increments, saturating at 8'hFF, and overflow_o is set.
- Marker injection:
  - Condition: drop_cnt!=0 and the FIFO has room (count<DEPTH || pop).
  - The marker {OVF_TAG, drop_cnt} is written instead of any input, and drop_cnt is cleared.
  - A valid input word in the same cycle is dropped and counted (drop_cnt becomes 1) toward the next marker.
  - The marker has priority over new input.
- overflow_o:
  - Set by any drop.
  - Cleared by clear_overflow_i; if a drop occurs in the same cycle, the set wins.
- Serializer FSM:
  - IDLE: if the FIFO is not empty, pop the head into the shift register, set beat=0 and go to SHIFT. trace_valid_o=0.
  - SHIFT: trace_valid_o=1 and trace_data_o=shift[PORT_W-1:0], LSB beat first. The beat is held stable until trace_ready_i.
  - On a handshake with beat<BEATS-1 (BEATS=WORD_W/PORT_W): shift right by PORT_W and increment beat.
  - On a handshake of the last beat: if the FIFO is non-empty, pop and reload (stay in SHIFT, no bubble); else go to IDLE.
- Latency: valid_i sampled at edge N, word in FIFO after N, popped at edge N+1, trace_valid_o=1 from N+1. This gives 2 cycles valid_i-to-first-beat when empty and idle.
- Throughput: one beat per cycle with trace_ready_i held high; back-to-back words are gapless.
- fill_level_o:
  - Registered FIFO count after push/pop; excludes the word in the shift register.
  - Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.

Decomposition:
- Package trace_port_pkg:
  - state enum (IDLE, SHIFT)
  - BEATS localparam function
  - OVF_TAG default
  - marker-build function
- Sub-module trace_word_fifo:
  - parameterized sync FIFO (WORD_W, DEPTH) with push, pop, full, empty and count.
  - Instantiated once.
- Top: drop/marker logic plus serializer FSM.

Test Plan:
- Single word: packet_word_i=32'hA1B2C3D4 for one cycle, ready=1 → valid from 2 cycles later; beats D4, C3, B2, A1 on 4 consecutive cycles; then valid=0; fill_level returns to 0.
- Backpressure: ready toggles 1,0,0,1,… → each beat held stable while ready=0; beat order unchanged; no lost or duplicated beats.
- Overflow: ready=0 and 12 consecutive valid words → fill_level=8, overflow_o=1 (the first 8 words occupy the FIFO at DEPTH=8).
  - Then ready=1 with no further input → after the first pop, marker 32'hFFFFFE04 is queued behind the buffered words.
  - The host sees the first 8 words, then the marker.
- Marker collision: the cycle the marker is written coincides with valid input → that input is dropped; a second marker with count 01 follows.
- Push-through at full: FIFO full, ready=1 on the last beat, valid input that cycle → word accepted, no drop, fill_level stays 8.
- Reset mid-beat: assert rst_i during beat 2 → trace_valid_o=0 immediately; after release, the next word starts at beat 0; overflow_o=0.
